// File: rtl/svm_label_vote.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// svm_label_vote
//
// Purpose:
//   Majority-vote smoother for the SVM classifier's per-sample label stream.
//   Collects WINDOW consecutive handshaken labels, or fewer if flush closes
//   the window early. It then presents one vote with the positive count and
//   the total count of the window. The vote is held until downstream accepts it.
//
// Parameters:
//   WINDOW   labels per vote (1..255)
//   TIE_VAL  vote value when positives exactly equal negatives
//   CNT_W    derived count width, $clog2(WINDOW+1); do not override
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   label        classifier decision (1 = positive)
//   label_valid  label is valid
//   label_ready  block accepts a label this cycle (high while collecting)
//   flush        single-cycle request to close the current partial window
//   vote         majority decision for the closed window
//   vote_pos     positive labels in the closed window
//   vote_n       labels in the closed window
//   vote_valid   vote/vote_pos/vote_n are valid
//   vote_ready   downstream accepts the vote
//
// Optional feature (macro SVM_VOTE_STATS_EN):
//   stat_labels     total handshaken labels, saturating at 32'hFFFFFFFF
//   stat_votes_pos  total accepted votes with vote=1, saturating
// ---------------------------------------------------------------------------
module svm_label_vote #(
  parameter int   WINDOW  = 8,
  parameter logic TIE_VAL = 1'b1,
  parameter int   CNT_W   = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             label,
  input  logic             label_valid,
  output logic             label_ready,
  input  logic             flush,
  output logic             vote,
  output logic [CNT_W-1:0] vote_pos,
  output logic [CNT_W-1:0] vote_n,
  output logic             vote_valid,
  input  logic             vote_ready
`ifdef SVM_VOTE_STATS_EN
  ,
  output logic [31:0]      stat_labels,
  output logic [31:0]      stat_votes_pos
`endif
);

  typedef enum logic {COLLECT, EMIT} state_t;

  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

  state_t           state;
  logic [CNT_W-1:0] pos_cnt;
  logic [CNT_W-1:0] n_cnt;

  logic             hs;
  logic [CNT_W-1:0] pos_next;
  logic [CNT_W-1:0] n_next;
  logic             close_win;
  logic [CNT_W:0]   pos_x2;
  logic [CNT_W:0]   n_ext;
  logic             vote_calc;

  assign label_ready = (state == COLLECT);

  // Counts including any label accepted this cycle. The window closes when
  // it fills, or on flush if the closed window would be non-empty (a label
  // arriving together with flush is counted first).
  // The vote compares 2*pos against n one bit wider so doubling cannot overflow.
  always_comb begin
    hs        = label_valid & label_ready;
    n_next    = n_cnt + CNT_W'(hs);
    pos_next  = pos_cnt + CNT_W'(hs & label);
    close_win = (hs && (n_next == WIN_CNT)) || (flush && ((n_cnt != '0) || hs));
    pos_x2    = {pos_next, 1'b0};
    n_ext     = {1'b0, n_next};
    if (pos_x2 > n_ext) begin
      vote_calc = 1'b1;
    end else if (pos_x2 < n_ext) begin
      vote_calc = 1'b0;
    end else begin
      vote_calc = TIE_VAL;
    end
  end

  // Two-state controller. The vote outputs are loaded only on the closing
  // edge, so they stay stable during back-pressure and keep their last value
  // after the vote is accepted. Counters clear on the vote handshake, so
  // label_ready returns one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      pos_cnt    <= '0;
      n_cnt      <= '0;
      vote       <= 1'b0;
      vote_pos   <= '0;
      vote_n     <= '0;
      vote_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          pos_cnt <= pos_next;
          n_cnt   <= n_next;
          if (close_win) begin
            state      <= EMIT;
            vote       <= vote_calc;
            vote_pos   <= pos_next;
            vote_n     <= n_next;
            vote_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (vote_ready) begin
            state      <= COLLECT;
            vote_valid <= 1'b0;
            pos_cnt    <= '0;
            n_cnt      <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef SVM_VOTE_STATS_EN
  // Lifetime statistics. They saturate instead of wrapping and are cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_labels    <= '0;
      stat_votes_pos <= '0;
    end else begin
      if (hs && (stat_labels != 32'hFFFF_FFFF)) begin
        stat_labels <= stat_labels + 32'd1;
      end
      if (vote_valid && vote_ready && vote && (stat_votes_pos != 32'hFFFF_FFFF)) begin
        stat_votes_pos <= stat_votes_pos + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_svm_label_vote.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_svm_label_vote
//
// Directed bench for svm_label_vote. Two WINDOW=8 instances share the same
// inputs: one with TIE_VAL=1 and one with TIE_VAL=0. A third instance uses
// WINDOW=1 and has its own inputs. Expected values are computed by hand from
// each label pattern.
// ---------------------------------------------------------------------------
module tb_svm_label_vote;

  logic clk = 1'b0;
  logic rst_n;
  logic label;
  logic label_valid;
  logic flush;
  logic vote_ready;

  logic       a_label_ready, a_vote, a_vote_valid;
  logic [3:0] a_vote_pos, a_vote_n;
  logic       b_label_ready, b_vote, b_vote_valid;
  logic [3:0] b_vote_pos, b_vote_n;

  logic       w_label, w_label_valid, w_flush, w_vote_ready;
  logic       w_label_ready, w_vote, w_vote_valid;
  logic [0:0] w_vote_pos, w_vote_n;

`ifdef SVM_VOTE_STATS_EN
  logic [31:0] a_stat_labels, a_stat_votes_pos;
  logic [31:0] b_stat_labels, b_stat_votes_pos;
  logic [31:0] w_stat_labels, w_stat_votes_pos;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svm_label_vote #(.WINDOW(8), .TIE_VAL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .label(label), .label_valid(label_valid),
    .label_ready(a_label_ready), .flush(flush), .vote(a_vote),
    .vote_pos(a_vote_pos), .vote_n(a_vote_n), .vote_valid(a_vote_valid),
    .vote_ready(vote_ready)
`ifdef SVM_VOTE_STATS_EN
    , .stat_labels(a_stat_labels), .stat_votes_pos(a_stat_votes_pos)
`endif
  );

  svm_label_vote #(.WINDOW(8), .TIE_VAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .label(label), .label_valid(label_valid),
    .label_ready(b_label_ready), .flush(flush), .vote(b_vote),
    .vote_pos(b_vote_pos), .vote_n(b_vote_n), .vote_valid(b_vote_valid),
    .vote_ready(vote_ready)
`ifdef SVM_VOTE_STATS_EN
    , .stat_labels(b_stat_labels), .stat_votes_pos(b_stat_votes_pos)
`endif
  );

  svm_label_vote #(.WINDOW(1), .TIE_VAL(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .label(w_label), .label_valid(w_label_valid),
    .label_ready(w_label_ready), .flush(w_flush), .vote(w_vote),
    .vote_pos(w_vote_pos), .vote_n(w_vote_n), .vote_valid(w_vote_valid),
    .vote_ready(w_vote_ready)
`ifdef SVM_VOTE_STATS_EN
    , .stat_labels(w_stat_labels), .stat_votes_pos(w_stat_votes_pos)
`endif
  );

  // One comparison: counts it, and on mismatch counts an error and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive the shared inputs for one clock, then return #1 after the edge.
  task automatic applyStimulus(input logic lab, input logic vld, input logic fl);
    label       = lab;
    label_valid = vld;
    flush       = fl;
    @(posedge clk);
    #1;
    label_valid = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;

    rst_n         = 1'b0;
    label         = 1'b0;
    label_valid   = 1'b0;
    flush         = 1'b0;
    vote_ready    = 1'b1;
    w_label       = 1'b0;
    w_label_valid = 1'b0;
    w_flush       = 1'b0;
    w_vote_ready  = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_vote_valid", a_vote_valid, 0);
    checkOutput("rst_label_ready", a_label_ready, 1);
    checkOutput("rst_vote", a_vote, 0);
    checkOutput("rst_vote_pos", a_vote_pos, 0);
    checkOutput("rst_vote_n", a_vote_n, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Window 1,1,1,1,1,0,0,0 back-to-back
    pat = 8'b0001_1111;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(pat[i], 1'b1, 1'b0);
      if (i == 6) checkOutput("maj_no_early_vote", a_vote_valid, 0);
    end
    checkOutput("maj_vote_valid", a_vote_valid, 1);
    checkOutput("maj_vote", a_vote, 1);
    checkOutput("maj_vote_pos", a_vote_pos, 5);
    checkOutput("maj_vote_n", a_vote_n, 8);
    checkOutput("maj_label_ready_low", a_label_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("maj_valid_one_cycle", a_vote_valid, 0);
    checkOutput("maj_label_ready_back", a_label_ready, 1);
    checkOutput("maj_vote_held", a_vote, 1);

    // Tie 1,1,1,1,0,0,0,0 on both tie settings
    pat = 8'b0000_1111;
    for (int i = 0; i < 8; i++) applyStimulus(pat[i], 1'b1, 1'b0);
    checkOutput("tie1_vote", a_vote, 1);
    checkOutput("tie0_vote", b_vote, 0);
    checkOutput("tie1_vote_pos", a_vote_pos, 4);
    checkOutput("tie0_vote_pos", b_vote_pos, 4);
    checkOutput("tie0_vote_valid", b_vote_valid, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Back-pressure: labels 0,1,0,0,1,0,0,0, then stall for 5 cycles
    vote_ready = 1'b0;
    pat = 8'b0001_0010;
    for (int i = 0; i < 8; i++) applyStimulus(pat[i], 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_vote_valid", a_vote_valid, 1);
      checkOutput("bp_vote", a_vote, 0);
      checkOutput("bp_vote_pos", a_vote_pos, 2);
      checkOutput("bp_vote_n", a_vote_n, 8);
      checkOutput("bp_label_ready", a_label_ready, 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    vote_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_release_valid", a_vote_valid, 0);
    checkOutput("bp_release_ready", a_label_ready, 1);

    // Flush with an empty window is ignored (also proves no stalled label leaked in)
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("flush_empty_valid", a_vote_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("flush_empty_valid2", a_vote_valid, 0);
    checkOutput("flush_empty_ready", a_label_ready, 1);

    // Flush after 0,1,0
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("flush3_vote_valid", a_vote_valid, 1);
    checkOutput("flush3_vote", a_vote, 0);
    checkOutput("flush3_vote_pos", a_vote_pos, 1);
    checkOutput("flush3_vote_n", a_vote_n, 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("flush3_ack", a_vote_valid, 0);

    // Flush coincident with the second label 1,1
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("flushco_vote_valid", a_vote_valid, 1);
    checkOutput("flushco_vote_n", a_vote_n, 2);
    checkOutput("flushco_vote_pos", a_vote_pos, 2);
    checkOutput("flushco_vote", a_vote, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset mid-window after 5 labels, then a full window of 1s
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_vote_n", a_vote_n, 0);
    checkOutput("midrst_label_ready", a_label_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (i == 6) checkOutput("midrst_no_stale_vote", a_vote_valid, 0);
    end
    checkOutput("midrst_vote_valid", a_vote_valid, 1);
    checkOutput("midrst_vote_n", a_vote_n, 8);
    checkOutput("midrst_vote_pos", a_vote_pos, 8);
    checkOutput("midrst_vote", a_vote, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // WINDOW=1 instance: each label is its own vote
    w_label = 1'b1;
    w_label_valid = 1'b1;
    @(posedge clk);
    #1;
    w_label_valid = 1'b0;
    checkOutput("w1_vote_valid_a", w_vote_valid, 1);
    checkOutput("w1_vote_a", w_vote, 1);
    checkOutput("w1_vote_n_a", w_vote_n, 1);
    @(posedge clk);
    #1;
    checkOutput("w1_ack", w_vote_valid, 0);
    w_label = 1'b0;
    w_label_valid = 1'b1;
    @(posedge clk);
    #1;
    w_label_valid = 1'b0;
    checkOutput("w1_vote_valid_b", w_vote_valid, 1);
    checkOutput("w1_vote_b", w_vote, 0);
    checkOutput("w1_vote_pos_b", w_vote_pos, 0);
    @(posedge clk);
    #1;

`ifdef SVM_VOTE_STATS_EN
    // Statistics: three full windows voting 1,0,1 from a fresh reset
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("stat_rst_labels", a_stat_labels, 0);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) applyStimulus((w != 1), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stat_labels", a_stat_labels, 24);
    checkOutput("stat_votes_pos", a_stat_votes_pos, 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stat_labels_flush", a_stat_labels, 24);
    checkOutput("stat_votes_pos_flush", a_stat_votes_pos, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
